nios2_core_cpu_mult_unit: RTL and testbench

Parametrised, fully pipelined integer multiplier for the Nios II core's M-stage multiply path. It computes the full 2×DATA_W product from four DATA_W/2 partial products, including the high×high term. The previous-generation multiply cell did not produce that term. Selectable result modes cover MUL, MULXUU, MULXSU and MULXSS. Valid tracking and a global pipeline enable let the core stall it in lockstep with the M/A stages.

---
 rtl/nios2_core_cpu_mult_unit.sv | 116 +++++++++++
 tb/tb_nios2_core_cpu_mult_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/nios2_core_cpu_mult_unit.sv
// rtl/nios2_core_cpu_mult_unit.sv - three-stage pipelined DATA_W x DATA_W multiplier
// Partial products -> unsigned sum -> signed-correction and result select.
module nios2_core_cpu_mult_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              in_valid,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  output logic              out_valid,
  output logic [1:0]        out_op,
  output logic [DATA_W-1:0] out_result
);

  localparam int HALF_W = DATA_W / 2;
  localparam int PROD_W = 2 * DATA_W;

  // Half-width operands, zero-extended so every product is full width.
  logic [DATA_W-1:0] a_lo, a_hi, b_lo, b_hi;
  logic              sign_a, sign_b;

  assign a_lo   = {{HALF_W{1'b0}}, in_src1[HALF_W-1:0]};
  assign a_hi   = {{HALF_W{1'b0}}, in_src1[DATA_W-1:HALF_W]};
  assign b_lo   = {{HALF_W{1'b0}}, in_src2[HALF_W-1:0]};
  assign b_hi   = {{HALF_W{1'b0}}, in_src2[DATA_W-1:HALF_W]};
  assign sign_a = in_op[1];
  assign sign_b = (in_op == 2'b11);

  logic              p_valid;
  logic [1:0]        p_op;
  logic [DATA_W-1:0] p_ll, p_lh, p_hl, p_hh;
  logic [DATA_W-1:0] p_corr_a, p_corr_b;
  logic              p_sign_a, p_sign_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_valid  <= 1'b0;
      p_op     <= 2'b00;
      p_ll     <= '0;
      p_lh     <= '0;
      p_hl     <= '0;
      p_hh     <= '0;
      p_corr_a <= '0;
      p_corr_b <= '0;
      p_sign_a <= 1'b0;
      p_sign_b <= 1'b0;
    end else if (en) begin
      p_valid  <= in_valid;
      p_op     <= in_op;
      p_ll     <= a_lo * b_lo;
      p_lh     <= a_lo * b_hi;
      p_hl     <= a_hi * b_lo;
      p_hh     <= a_hi * b_hi;
      p_corr_a <= (sign_a && in_src1[DATA_W-1]) ? in_src2 : '0;
      p_corr_b <= (sign_b && in_src2[DATA_W-1]) ? in_src1 : '0;
      p_sign_a <= sign_a;
      p_sign_b <= sign_b;
    end
  end

  // Middle sum keeps its carry bit before being placed at HALF_W.
  logic [DATA_W:0]   mid_sum;
  logic [PROD_W-1:0] mid_ext;
  logic [PROD_W-1:0] full_sum;
  logic [DATA_W-1:0] corr_sum;

  always_comb begin
    mid_sum  = {1'b0, p_lh} + {1'b0, p_hl};
    mid_ext  = {{(HALF_W-1){1'b0}}, mid_sum, {HALF_W{1'b0}}};
    full_sum = {p_hh, p_ll} + mid_ext;
    corr_sum = (p_sign_a ? p_corr_a : '0) + (p_sign_b ? p_corr_b : '0);
  end

  logic              s_valid;
  logic [1:0]        s_op;
  logic [PROD_W-1:0] s_sum;
  logic [DATA_W-1:0] s_corr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_valid <= 1'b0;
      s_op    <= 2'b00;
      s_sum   <= '0;
      s_corr  <= '0;
    end else if (en) begin
      s_valid <= p_valid;
      s_op    <= p_op;
      s_sum   <= full_sum;
      s_corr  <= corr_sum;
    end
  end

  // Signed high halves are the unsigned high half minus the sign corrections.
  logic [DATA_W-1:0] result_sel;

  always_comb begin
    if (s_op == 2'b00) result_sel = s_sum[DATA_W-1:0];
    else               result_sel = s_sum[PROD_W-1:DATA_W] - s_corr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_op     <= 2'b00;
      out_result <= '0;
    end else if (en) begin
      out_valid  <= s_valid;
      out_op     <= s_op;
      out_result <= result_sel;
    end
  end

endmodule

// File: tb/tb_nios2_core_cpu_mult_unit.sv
// tb/tb_nios2_core_cpu_mult_unit.sv - bench for nios2_core_cpu_mult_unit
// Directed corner cases plus randomized scoreboard against a 64-bit product model.
module tb_nios2_core_cpu_mult_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] in_src1 = '0, in_src2 = '0;
  logic        out_valid;
  logic [1:0]  out_op;
  logic [31:0] out_result;

  logic        v16 = 1'b0;
  logic [1:0]  op16 = 2'b00;
  logic [15:0] a16 = '0, b16 = '0;
  logic        ov16;
  logic [1:0]  oop16;
  logic [15:0] ores16;

  int tests = 0;
  int fails = 0;
  int edges = 0;

  typedef struct {
    int          edge_n;
    logic [1:0]  op;
    logic [31:0] res;
  } exp_t;
  exp_t        sb[$];
  logic        exp_v = 1'b0;
  logic [1:0]  exp_op = 2'b00;
  logic [31:0] exp_res = '0;

  always #5 clk = ~clk;

  nios2_core_cpu_mult_unit #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2),
    .out_valid(out_valid), .out_op(out_op), .out_result(out_result)
  );

  nios2_core_cpu_mult_unit #(.DATA_W(16)) dut16 (
    .clk(clk), .reset(reset), .en(en), .in_valid(v16), .in_op(op16),
    .in_src1(a16), .in_src2(b16),
    .out_valid(ov16), .out_op(oop16), .out_result(ores16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Exact product of the operands interpreted per op, then the requested half.
  function automatic logic [31:0] ref32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb_;
    logic [63:0] p;
    sa  = op[1]       ? longint'($signed(a)) : longint'({32'b0, a});
    sb_ = (op == 2'b11) ? longint'($signed(b)) : longint'({32'b0, b});
    p   = 64'(sa * sb_);
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One clock: drive at negedge, scoreboard on the posedge, compare at the next negedge.
  task automatic step(input logic e, input logic v, input logic [1:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    en = e; in_valid = v; in_op = op; in_src1 = a; in_src2 = b;
    @(posedge clk);
    if (e) begin
      edges++;
      if (v) sb.push_back('{edges, op, ref32(op, a, b)});
    end
    @(negedge clk);
    if (e) begin
      if (sb.size() > 0 && sb[0].edge_n + 2 == edges) begin
        exp_v = 1'b1; exp_op = sb[0].op; exp_res = sb[0].res;
        void'(sb.pop_front());
      end else begin
        exp_v = 1'b0;
      end
    end
    check("sb_valid", 32'(out_valid), 32'(exp_v));
    if (exp_v) begin
      check("sb_op", 32'(out_op), 32'(exp_op));
      check("sb_result", out_result, exp_res);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
  endtask

  logic [31:0] frozen_res;

  initial begin
    #1;
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_op", 32'(out_op), 32'd0);
    check("reset_result", out_result, 32'd0);
    check("reset_valid16", 32'(ov16), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // All-ones operands, four ops back-to-back.
    step(1'b1, 1'b1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("ones_mul", out_result, 32'h0000_0001);
    check("ones_mul_op", 32'(out_op), 32'd0);
    step(1'b1, 1'b1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("ones_mulxuu", out_result, 32'hFFFF_FFFE);
    check("ones_mulxuu_op", 32'(out_op), 32'd1);
    step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    check("ones_mulxsu", out_result, 32'hFFFF_FFFF);
    check("ones_mulxsu_v", 32'(out_valid), 32'd1);
    step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    check("ones_mulxss", out_result, 32'h0000_0000);
    check("ones_mulxss_op", 32'(out_op), 32'd3);

    // Most-negative operands.
    step(1'b1, 1'b1, 2'b11, 32'h8000_0000, 32'h8000_0000);
    step(1'b1, 1'b1, 2'b01, 32'h8000_0000, 32'h8000_0000);
    step(1'b1, 1'b1, 2'b00, 32'h8000_0000, 32'h8000_0000);
    check("neg_mulxss", out_result, 32'h4000_0000);
    step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    check("neg_mulxuu", out_result, 32'h4000_0000);
    step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    check("neg_mul", out_result, 32'h0000_0000);
    check("neg_mul_v", 32'(out_valid), 32'd1);
    idle(2);

    // Stall: one enabled edge, five frozen cycles, then two more edges.
    step(1'b1, 1'b1, 2'b01, 32'h0001_0000, 32'h0001_0000);
    frozen_res = out_result;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 2'b11, 32'hFFFF_FFFF, 32'h1234_5678);
      check("stall_valid", 32'(out_valid), 32'd0);
      check("stall_result", out_result, frozen_res);
    end
    step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    check("stall_one_edge", 32'(out_valid), 32'd0);
    step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    check("stall_done_v", 32'(out_valid), 32'd1);
    check("stall_done_res", out_result, 32'h0000_0001);

    // Narrow instance.
    v16 = 1'b1; op16 = 2'b11; a16 = 16'h8000; b16 = 16'h0002;
    step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    op16 = 2'b10;
    step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    op16 = 2'b01;
    step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    check("w16_mulxss", 32'(ores16), 32'h0000_FFFF);
    check("w16_mulxss_v", 32'(ov16), 32'd1);
    op16 = 2'b00; a16 = 16'h1234; b16 = 16'h5678;
    step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    check("w16_mulxsu", 32'(ores16), 32'h0000_FFFF);
    v16 = 1'b0;
    step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    check("w16_mulxuu", 32'(ores16), 32'h0000_0001);
    step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    check("w16_mul", 32'(ores16), 32'h0000_0060);
    check("w16_mul_op", 32'(oop16), 32'd0);
    step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    check("w16_drain_v", 32'(ov16), 32'd0);

    // Asynchronous reset with three operations in flight.
    step(1'b1, 1'b1, 2'b01, 32'h0000_0003, 32'h0000_0005);
    step(1'b1, 1'b1, 2'b00, 32'h0000_0007, 32'h0000_0009);
    step(1'b1, 1'b1, 2'b11, 32'hFFFF_FFF0, 32'h0000_0011);
    en = 1'b1; in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_result", out_result, 32'd0);
    check("rst_mid_op", 32'(out_op), 32'd0);
    sb.delete();
    exp_v = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
      check("rst_after_valid", 32'(out_valid), 32'd0);
    end

    // Randomized traffic with enable and valid gaps.
    for (int i = 0; i < 20000; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
           2'($urandom_range(0, 3)), pick_operand(), pick_operand());
    end
    idle(3);
    check("drain_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
